// File: rtl/piso_shift_out.sv
// Parallel-in, serial-out converter: takes a REG_NUM-word frame in one cycle and
// emits it one word per handshake, highest slice first, slice 0 flagged as last.
module piso_shift_out #(
   parameter int DATA_WIDTH = 16,
   parameter int REG_NUM    = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [REG_NUM*DATA_WIDTH*2-1:0] p_in,
   input  logic                            p_valid,
   output logic                            p_ready,
   output logic [DATA_WIDTH*2-1:0]         s_out,
   output logic                            s_valid,
   input  logic                            s_ready,
   output logic                            s_last
);

   localparam int WW = DATA_WIDTH * 2;
   localparam int CW = $clog2(REG_NUM) + 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                      state;
   logic [CW-1:0]               cnt;
   logic [REG_NUM-1:0][WW-1:0]  buf_q;

   logic cnt_zero, load, s_hs;

   assign cnt_zero = (cnt == '0);
   assign s_valid  = (state == SHIFT);
   assign s_last   = s_valid & cnt_zero;
   // Accept a new frame while idle, or on the same edge the last word leaves.
   assign p_ready  = (state == IDLE) | (s_ready & cnt_zero);
   assign load     = p_valid & p_ready;
   assign s_hs     = s_valid & s_ready;
   assign s_out    = buf_q[REG_NUM-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         buf_q <= '0;
      end else if (load) begin
         buf_q <= p_in;
         cnt   <= CW'(REG_NUM - 1);
         state <= SHIFT;
      end else if (s_hs) begin
         if (!cnt_zero) begin
            for (int i = REG_NUM - 1; i > 0; i--)
               buf_q[i] <= buf_q[i-1];
            cnt <= cnt - CW'(1);
         end else begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_piso_shift_out.sv
// Directed bench for piso_shift_out: REG_NUM=4 instance for frame, back-to-back,
// backpressure, reset and round-trip cases; REG_NUM=1 instance for streaming.
module tb_piso_shift_out;

   localparam int DW = 16;
   localparam int RN = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [RN*32-1:0] p_in = '0;
   logic            p_valid = 1'b0;
   logic            p_ready;
   logic [31:0]     s_out;
   logic            s_valid;
   logic            s_ready = 1'b0;
   logic            s_last;

   logic [31:0]     p_in1 = '0;
   logic            p_valid1 = 1'b0;
   logic            p_ready1;
   logic [31:0]     s_out1;
   logic            s_valid1;
   logic            s_ready1 = 1'b0;
   logic            s_last1;

   int tests = 0;
   int fails = 0;

   piso_shift_out #(.DATA_WIDTH(DW), .REG_NUM(RN)) dut (
      .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready),
      .s_out(s_out), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last));

   piso_shift_out #(.DATA_WIDTH(DW), .REG_NUM(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .p_in(p_in1), .p_valid(p_valid1), .p_ready(p_ready1),
      .s_out(s_out1), .s_valid(s_valid1), .s_ready(s_ready1), .s_last(s_last1));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check the serial side in one go: valid, last and data.
   task automatic chk_word(input string tag, input logic v, input logic l, input logic [31:0] d);
      chk({tag, ".valid"}, {127'd0, s_valid}, {127'd0, v});
      chk({tag, ".last"},  {127'd0, s_last},  {127'd0, l});
      chk({tag, ".data"},  {96'd0, s_out},    {96'd0, d});
   endtask

   logic [127:0] fa, fb, fc, rt;
   logic [31:0]  w;

   initial begin
      fa = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      fb = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
      fc = {32'hDEADBEEF, 32'h0BADF00D, 32'hCAFEBABE, 32'h12345678};

      // Reset state
      #2;
      chk_word("rst", 1'b0, 1'b0, 32'h0);
      chk("rst.p_ready", {127'd0, p_ready}, 128'd1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("idle.p_ready", {127'd0, p_ready}, 128'd1);
      chk_word("idle", 1'b0, 1'b0, 32'h0);

      // Single frame, s_ready held high
      s_ready = 1'b1;
      p_in = fa; p_valid = 1'b1;
      tick();
      p_valid = 1'b0; p_in = '0;
      chk_word("f1.w3", 1'b1, 1'b0, 32'h44444444);
      chk("f1.w3.p_ready", {127'd0, p_ready}, 128'd0);
      tick(); chk_word("f1.w2", 1'b1, 1'b0, 32'h33333333);
      tick(); chk_word("f1.w1", 1'b1, 1'b0, 32'h22222222);
      tick(); chk_word("f1.w0", 1'b1, 1'b1, 32'h11111111);
      chk("f1.w0.p_ready", {127'd0, p_ready}, 128'd1);
      tick(); chk_word("f1.after", 1'b0, 1'b0, 32'h11111111);

      // Back-to-back frames A then B with no bubble
      p_in = fa; p_valid = 1'b1;
      tick();
      p_in = fb;
      chk_word("b2b.a3", 1'b1, 1'b0, 32'h44444444);
      chk("b2b.a3.p_ready", {127'd0, p_ready}, 128'd0);
      tick(); chk_word("b2b.a2", 1'b1, 1'b0, 32'h33333333);
      chk("b2b.a2.p_ready", {127'd0, p_ready}, 128'd0);
      tick(); chk_word("b2b.a1", 1'b1, 1'b0, 32'h22222222);
      tick(); chk_word("b2b.a0", 1'b1, 1'b1, 32'h11111111);
      chk("b2b.a0.p_ready", {127'd0, p_ready}, 128'd1);
      tick();
      p_valid = 1'b0;
      chk_word("b2b.b3", 1'b1, 1'b0, 32'h88888888);
      chk("b2b.b3.p_ready", {127'd0, p_ready}, 128'd0);
      tick(); chk_word("b2b.b2", 1'b1, 1'b0, 32'h77777777);
      tick(); chk_word("b2b.b1", 1'b1, 1'b0, 32'h66666666);
      tick(); chk_word("b2b.b0", 1'b1, 1'b1, 32'h55555555);
      tick(); chk_word("b2b.idle", 1'b0, 1'b0, 32'h55555555);

      // Backpressure on the second word, with frame B pending
      p_in = fa; p_valid = 1'b1;
      tick();
      p_in = fb;
      chk_word("bp.w3", 1'b1, 1'b0, 32'h44444444);
      tick();
      chk_word("bp.w2", 1'b1, 1'b0, 32'h33333333);
      s_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp.hold.p_ready", {127'd0, p_ready}, 128'd0);
         tick();
         chk_word("bp.hold", 1'b1, 1'b0, 32'h33333333);
      end
      s_ready = 1'b1;
      tick(); chk_word("bp.w1", 1'b1, 1'b0, 32'h22222222);
      tick(); chk_word("bp.w0", 1'b1, 1'b1, 32'h11111111);
      tick();
      p_valid = 1'b0;
      chk_word("bp.b3", 1'b1, 1'b0, 32'h88888888);
      tick(); chk_word("bp.b2", 1'b1, 1'b0, 32'h77777777);
      tick(); chk_word("bp.b1", 1'b1, 1'b0, 32'h66666666);
      tick(); chk_word("bp.b0", 1'b1, 1'b1, 32'h55555555);
      tick(); chk_word("bp.idle", 1'b0, 1'b0, 32'h55555555);

      // Asynchronous reset mid-frame
      p_in = fa; p_valid = 1'b1;
      tick();
      p_valid = 1'b0;
      tick();
      chk_word("mrst.w2", 1'b1, 1'b0, 32'h33333333);
      #1 rst_n = 1'b0;
      #1 chk_word("mrst.async", 1'b0, 1'b0, 32'h0);
      tick();
      rst_n = 1'b1;
      chk("mrst.p_ready", {127'd0, p_ready}, 128'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_word("mrst.quiet", 1'b0, 1'b0, 32'h0);
      end
      p_in = fb; p_valid = 1'b1;
      tick();
      p_valid = 1'b0;
      chk_word("mrst.b3", 1'b1, 1'b0, 32'h88888888);
      tick(); chk_word("mrst.b2", 1'b1, 1'b0, 32'h77777777);
      tick(); chk_word("mrst.b1", 1'b1, 1'b0, 32'h66666666);
      tick(); chk_word("mrst.b0", 1'b1, 1'b1, 32'h55555555);
      tick();

      // Round trip: collect words as a SIPO would (first word lands in top slice)
      rt = '0;
      p_in = fc; p_valid = 1'b1;
      tick();
      p_valid = 1'b0; p_in = '0;
      begin
         int n = 0;
         int guard = 0;
         while (n < RN && guard < 20) begin
            if (s_valid && s_ready) begin
               rt = {rt[95:0], s_out};
               n++;
               if (s_last) guard = 20;
            end
            if (n < RN) tick();
            guard++;
         end
         chk("rt.count", 128'(n), 128'(RN));
      end
      chk("rt.frame", rt, fc);
      tick();
      chk_word("rt.idle", 1'b0, 1'b0, 32'hDEADBEEF ^ 32'hDEADBEEF ^ 32'h12345678);

      // REG_NUM=1 instance: load and emit every cycle
      s_ready1 = 1'b1;
      p_valid1 = 1'b1;
      w = 32'h00000100;
      p_in1 = w;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rn1.valid", {127'd0, s_valid1}, 128'd1);
         chk("rn1.last",  {127'd0, s_last1},  128'd1);
         chk("rn1.data",  {96'd0, s_out1},    {96'd0, w});
         chk("rn1.p_ready", {127'd0, p_ready1}, 128'd1);
         w = w + 32'd1;
         p_in1 = w;
      end
      p_valid1 = 1'b0;
      tick();
      chk("rn1.drain", {127'd0, s_valid1}, 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/piso_shift_out.md
Name: piso_shift_out

Overview:
- Parallel-in, serial-out converter with valid/ready handshakes on both sides.
- Accepts a frame of REG_NUM complex words, each DATA_WIDTH*2 bits (I/Q packed), in one cycle.
- Emits the frame one word per handshake: highest slice first, slice 0 last.
- Sits at the output of the PE array and feeds the serial stream of the next stage or the SIPO collector. SIPO(PISO(frame)) reproduces the frame slice-for-slice.

Parameters:
- DATA_WIDTH, 16, bit width of one real component; one word is DATA_WIDTH*2 bits.
- REG_NUM, 8, words per frame (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- p_in  in  REG_NUM*DATA_WIDTH*2  parallel frame; slice j = bits [(j+1)*DATA_WIDTH*2-1 : j*DATA_WIDTH*2].
- p_valid  in  1  p_in holds a frame.
- p_ready  out  1  block accepts p_in this cycle.
- s_out  out  DATA_WIDTH*2  current serial word.
- s_valid  out  1  s_out valid.
- s_ready  in  1  downstream accepts s_out.
- s_last  out  1  s_out is slice 0, the final word of the frame.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Storage: word array buf[0..REG_NUM-1] of DATA_WIDTH*2 bits; down-counter cnt of width clog2(REG_NUM)+1.
- Output drive: s_out = buf[REG_NUM-1]. There is no combinational path from p_in to s_out.
- Reset (rst_n=0, takes effect immediately):
  - state=IDLE, cnt=0, all buf entries=0.
  - s_valid=0, s_last=0, s_out=0, p_ready=1 (after reset is released).
- Load handshake: p_valid & p_ready at a rising edge.
  - buf[j] <= slice j of p_in.
  - cnt <= REG_NUM-1.
  - state <= SHIFT.
  - s_valid is 1 from the next cycle. Latency p_in to first s_out word = 1 cycle.
- States:
  - IDLE: s_valid=0, p_ready=1. On load, go to SHIFT.
  - SHIFT: s_valid=1, s_last=(cnt==0). p_ready = s_ready & (cnt==0).
- Output handshake (s_valid & s_ready):
  - If cnt>0: buf[i] <= buf[i-1] for i=REG_NUM-1..1; cnt <= cnt-1.
  - If cnt==0 (last word):
    - p_valid=1: load the new frame in the same edge and stay in SHIFT. There is no bubble, so throughput is 1 word/cycle across frames.
    - p_valid=0: go to IDLE; s_valid and s_last fall.
- Stall: s_valid & !s_ready holds s_out, s_last, cnt and buf unchanged. p_ready=0 throughout.
- AXI-style rules:
  - s_valid, once asserted, does not drop until the word is accepted.
  - p_in is sampled only on the load handshake; it is ignored otherwise.
- REG_NUM=1: every word has s_last=1. With p_valid and s_ready held high, the block loads and emits every cycle.
- Reset mid-frame: the remaining words are discarded and no partial frame is emitted afterwards.
- The block has no internal data arithmetic; words pass bit-exact.

Test Plan:
- DATA_WIDTH=16, REG_NUM=4, s_ready=1. Load p_in={32'h44444444,32'h33333333,32'h22222222,32'h11111111} -> s_out = 44444444, 33333333, 22222222, 11111111 on 4 consecutive cycles starting 1 cycle after load. s_last=1 only on 11111111. s_valid=0 the cycle after.
- Back-to-back: p_valid held high with frames A then B, s_ready=1 -> 8 contiguous valid words, A slices 3..0 then B slices 3..0. p_ready pulses only on cycles with cnt==0. There is no idle cycle between frames.
- Backpressure: s_ready low for 3 cycles on the second word of the frame above -> s_out holds 33333333 with s_valid=1 for 3 cycles, then the sequence resumes. p_ready stays 0; a pending p_valid frame is not taken early.
- Reset mid-frame: assert rst_n=0 after the second word -> s_valid, s_last and s_out go to 0 immediately, without waiting for a clock edge. After release, p_ready=1 and no leftover words appear. A fresh frame then emits correctly.
- Round trip with SIPO (REG_NUM=4): chain s_out into the SIPO s_in, and sample SIPO p_out one cycle after the s_last handshake -> result equals the original p_in.
- REG_NUM=1 build: p_valid=1 and s_ready=1 continuously with incrementing 32-bit words -> each word appears 1 cycle later, s_last=1 on every word, throughput 1 word/cycle.
